// File: rtl/arm_alu_pkg.sv
// Shared definitions for the ARMv4 data-processing ALU: opcode encodings,
// flag bit positions and the opcode classification helper.
package arm_alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_EOR = 4'h1,
    ALU_SUB = 4'h2,
    ALU_RSB = 4'h3,
    ALU_ADD = 4'h4,
    ALU_ADC = 4'h5,
    ALU_SBC = 4'h6,
    ALU_RSC = 4'h7,
    ALU_TST = 4'h8,
    ALU_TEQ = 4'h9,
    ALU_CMP = 4'hA,
    ALU_CMN = 4'hB,
    ALU_ORR = 4'hC,
    ALU_MOV = 4'hD,
    ALU_BIC = 4'hE,
    ALU_MVN = 4'hF
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // True for opcodes whose C/V come from the adder rather than the shifter.
  function automatic logic is_arith(input alu_op_e op);
    case (op)
      ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC,
      ALU_SBC, ALU_RSC, ALU_CMP, ALU_CMN: is_arith = 1'b1;
      default:                             is_arith = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_alu_add_with_carry32.sv
// 32-bit AddWithCarry: unsigned carry-out and signed overflow of a+b+cin.
// Operands arrive already inverted where the operation is a subtract.
module arm_alu_add_with_carry32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow
);

  logic [32:0] sum;

  assign sum      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
  assign result   = sum[31:0];
  assign carry    = sum[32];
  assign overflow = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/arm_alu.sv
// ARMv4 data-processing ALU: operand inversion, logical ops and NZCV
// generation feeding a single output register stage.
module arm_alu
  import arm_alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [3:0]  i_nzcv,
  input  logic [3:0]  i_opcode,
  input  logic        i_shift_carry,
  output logic [31:0] o_result,
  output logic [3:0]  o_nzcv
);

  alu_op_e     op;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_result;
  logic        add_carry;
  logic        add_overflow;
  logic [31:0] logic_result;
  logic [31:0] result_d, result_q;
  logic [3:0]  nzcv_d, nzcv_q;

  assign op = alu_op_e'(i_opcode);

  // Subtracts become additions of the inverted operand; the +1 rides on cin.
  always_comb begin
    add_a   = i_op1;
    add_b   = i_op2;
    add_cin = 1'b0;
    case (op)
      ALU_SUB, ALU_CMP: begin add_b = ~i_op2; add_cin = 1'b1;             end
      ALU_RSB:          begin add_a = ~i_op1; add_cin = 1'b1;             end
      ALU_ADC:          begin                 add_cin = i_nzcv[FLAG_C];   end
      ALU_SBC:          begin add_b = ~i_op2; add_cin = i_nzcv[FLAG_C];   end
      ALU_RSC:          begin add_a = ~i_op1; add_cin = i_nzcv[FLAG_C];   end
      default:          begin                                             end
    endcase
  end

  arm_alu_add_with_carry32 u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .result   (add_result),
    .carry    (add_carry),
    .overflow (add_overflow)
  );

  always_comb begin
    logic_result = 32'd0;
    case (op)
      ALU_AND, ALU_TST: logic_result = i_op1 & i_op2;
      ALU_EOR, ALU_TEQ: logic_result = i_op1 ^ i_op2;
      ALU_ORR:          logic_result = i_op1 | i_op2;
      ALU_MOV:          logic_result = i_op2;
      ALU_BIC:          logic_result = i_op1 & ~i_op2;
      ALU_MVN:          logic_result = ~i_op2;
      default:          logic_result = 32'd0;
    endcase
  end

  always_comb begin
    if (is_arith(op)) begin
      result_d       = add_result;
      nzcv_d[FLAG_C] = add_carry;
      nzcv_d[FLAG_V] = add_overflow;
    end else begin
      result_d       = logic_result;
      nzcv_d[FLAG_C] = i_shift_carry;
      nzcv_d[FLAG_V] = i_nzcv[FLAG_V];
    end
    nzcv_d[FLAG_N] = result_d[31];
    nzcv_d[FLAG_Z] = (result_d == 32'd0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_q <= 32'd0;
      nzcv_q   <= 4'd0;
    end else begin
      result_q <= result_d;
      nzcv_q   <= nzcv_d;
    end
  end

  assign o_result = result_q;
  assign o_nzcv   = nzcv_q;

endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: directed vectors with hand-derived
// results, reset behaviour, and an all-opcode sweep against a reference model.
module tb_arm_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  nzcv_in;
  logic [3:0]  opcode;
  logic        shift_carry;
  logic [31:0] result;
  logic [3:0]  nzcv_out;

  int n_checks;
  int n_fail;

  arm_alu dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_op1         (op1),
    .i_op2         (op2),
    .i_nzcv        (nzcv_in),
    .i_opcode      (opcode),
    .i_shift_carry (shift_carry),
    .o_result      (result),
    .o_nzcv        (nzcv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] f, input logic sc);
    opcode      = op;
    op1         = a;
    op2         = b;
    nzcv_in     = f;
    shift_carry = sc;
  endtask

  // Drive inputs, cross one rising edge, then compare away from the edge.
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] f, input logic sc,
                     input logic [31:0] exp_res, input logic [3:0] exp_nzcv);
    drive(op, a, b, f, sc);
    @(posedge clk);
    #1;
    check_value({tag, ".res"}, result, exp_res);
    check_value({tag, ".nzcv"}, {28'd0, nzcv_out}, {28'd0, exp_nzcv});
  endtask

  // Reference model written in plain subtract/compare terms.
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] f,
                                        input logic sc);
    logic [31:0] r;
    logic        c, v;
    logic        cin;
    logic [32:0] sa, sb, sr;
    logic [32:0] ua, ub;
    cin = f[1];
    c   = sc;
    v   = f[0];
    r   = 32'd0;
    sa  = {a[31], a};
    sb  = {b[31], b};
    ua  = {1'b0, a};
    ub  = {1'b0, b};
    sr  = 33'd0;
    case (op)
      4'h0, 4'h8: r = a & b;
      4'h1, 4'h9: r = a ^ b;
      4'hC:       r = a | b;
      4'hD:       r = b;
      4'hE:       r = a & ~b;
      4'hF:       r = ~b;
      4'h4, 4'hB: begin r = a + b;       c = (ua + ub) > 33'hFFFFFFFF;       sr = sa + sb;       v = sr[32] ^ sr[31]; end
      4'h5:       begin r = a + b + {31'd0, cin}; c = (ua + ub + {32'd0, cin}) > 33'hFFFFFFFF;
                        sr = sa + sb + {32'd0, cin}; v = sr[32] ^ sr[31]; end
      4'h2, 4'hA: begin r = a - b;       c = (ua >= ub);                     sr = sa - sb;       v = sr[32] ^ sr[31]; end
      4'h3:       begin r = b - a;       c = (ub >= ua);                     sr = sb - sa;       v = sr[32] ^ sr[31]; end
      4'h6:       begin r = a - b - {31'd0, ~cin}; c = (ua >= ub + {32'd0, ~cin});
                        sr = sa - sb - {32'd0, ~cin}; v = sr[32] ^ sr[31]; end
      4'h7:       begin r = b - a - {31'd0, ~cin}; c = (ub >= ua + {32'd0, ~cin});
                        sr = sb - sa - {32'd0, ~cin}; v = sr[32] ^ sr[31]; end
      default:    r = 32'd0;
    endcase
    model = {r, r[31], (r == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       pick_operand = 32'h0000_0000;
      1:       pick_operand = 32'hFFFF_FFFF;
      2:       pick_operand = 32'h8000_0000;
      3:       pick_operand = 32'h7FFF_FFFF;
      default: pick_operand = $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(4'h4, 32'h1234_5678, 32'h1111_1111, 4'hF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_value("reset.res", result, 32'd0);
    check_value("reset.nzcv", {28'd0, nzcv_out}, 32'd0);
    rst_n = 1'b1;

    run("add_ovf", 4'h4, 32'h7FFF_FFFF, 32'h0000_0001, 4'h0, 1'b0, 32'h8000_0000, 4'b1001);
    // Output must still hold the ADD result before the next edge.
    drive(4'h2, 32'd5, 32'd5, 4'h0, 1'b0);
    #2;
    check_value("latency.hold", result, 32'h8000_0000);
    run("sub_eq", 4'h2, 32'd5, 32'd5, 4'h0, 1'b0, 32'h0000_0000, 4'b0110);
    run("sub_borrow", 4'h2, 32'd0, 32'd1, 4'h0, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    run("rsb", 4'h3, 32'd3, 32'd1, 4'h0, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    run("adc_wrap", 4'h5, 32'hFFFF_FFFF, 32'd0, 4'b0010, 1'b0, 32'h0000_0000, 4'b0110);
    run("sbc", 4'h6, 32'd5, 32'd3, 4'b0000, 1'b0, 32'h0000_0001, 4'b0010);
    run("mvn", 4'hF, 32'd0, 32'hFFFF_FFFF, 4'b0001, 1'b1, 32'h0000_0000, 4'b0111);
    run("bic", 4'hE, 32'hF0F0_F0F0, 32'hFF00_0000, 4'b0000, 1'b0, 32'h00F0_F0F0, 4'b0000);
    run("cmn_ovf", 4'hB, 32'h8000_0000, 32'h8000_0000, 4'h0, 1'b0, 32'h0000_0000, 4'b0111);
    run("rsc_c0", 4'h7, 32'd1, 32'd4, 4'b0000, 1'b0, 32'h0000_0002, 4'b0010);

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    run("pre_rst", 4'h4, 32'd1, 32'd2, 4'h0, 1'b0, 32'd3, 4'b0000);
    drive(4'h4, 32'd10, 32'd20, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_rst.res", result, 32'd0);
    check_value("async_rst.nzcv", {28'd0, nzcv_out}, 32'd0);
    @(posedge clk);
    #1;
    check_value("rst_hold.res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("post_rst.res", result, 32'd30);
    check_value("post_rst.nzcv", {28'd0, nzcv_out}, 32'd0);

    // Sweep: each vector is applied to all 16 opcodes so CMP/CMN/TST/TEQ
    // see exactly the inputs their base operations saw.
    for (int vi = 0; vi < 20; vi++) begin
      logic [31:0] a, b;
      logic [3:0]  f;
      logic        sc;
      logic [35:0] exp;
      a  = pick_operand();
      b  = pick_operand();
      f  = 4'($urandom_range(0, 15));
      sc = 1'($urandom_range(0, 1));
      for (int oi = 0; oi < 16; oi++) begin
        exp = model(4'(oi), a, b, f, sc);
        drive(4'(oi), a, b, f, sc);
        @(posedge clk);
        #1;
        check_value($sformatf("sweep%0d_op%0h.res", vi, oi), result, exp[35:4]);
        check_value($sformatf("sweep%0d_op%0h.nzcv", vi, oi), {28'd0, nzcv_out}, {28'd0, exp[3:0]});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
